// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery datapath blocks (mont_to_domain, mont_mult).
// Holds the default operand sizes and the 2-bit FSM state encoding.
package mont_pkg;

    localparam int MONT_WIDTH = 32;
    localparam int MONT_LEN_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DBL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/mod_dbl.sv
// Combinational modular doubler: dbl = (2*acc) mod modulus, assuming acc < modulus.
// Works at WIDTH+1 bits so the bit shifted out of acc takes part in the compare.
module mod_dbl #(
    parameter int WIDTH = mont_pkg::MONT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] dbl
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] diff;

    assign t     = {acc, 1'b0};
    assign m_ext = {1'b0, modulus};
    assign diff  = t - m_ext;

    // With acc < modulus, 2*acc < 2*modulus, so a single subtract is enough.
    assign dbl = (t >= m_ext) ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/mont_to_domain.sv
// Bit-serial conversion into the Montgomery domain: mm_out = (num_1 * 2^len) mod modulus.
// One modular doubling per clock, using the same start/end handshake as mont_mult.
module mont_to_domain
    import mont_pkg::*;
#(
    parameter int WIDTH = MONT_WIDTH,
    parameter int LEN_W = MONT_LEN_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             md_start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] num_1,
    input  logic [WIDTH-1:0] modulus,
    output logic             md_end,
    output logic             md_err,
    output logic             busy,
    output logic [WIDTH-1:0] mm_out
);

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dbl;
    logic             err;
    logic             load_err;

    mod_dbl #(.WIDTH(WIDTH)) u_mod_dbl (
        .acc     (acc),
        .modulus (mod_q),
        .dbl     (dbl)
    );

    assign load_err = (mod_q == '0) | ~mod_q[0] | (num_q >= mod_q);

    // The md_end cycle still counts as busy; a new start is taken only once it has passed.
    assign busy = (state != S_IDLE) | md_end;

    // NOTE: every register here is state, so all use non-blocking assignments and async reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            len_q  <= '0;
            cnt    <= '0;
            num_q  <= '0;
            mod_q  <= '0;
            acc    <= '0;
            err    <= 1'b0;
            md_end <= 1'b0;
            md_err <= 1'b0;
            mm_out <= '0;
        end else begin
            md_end <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (md_start && !md_end) begin
                        len_q <= len;
                        num_q <= num_1;
                        mod_q <= modulus;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    err <= load_err;
                    cnt <= len_q;
                    if (load_err) begin
                        acc   <= '0;
                        state <= S_DONE;
                    end else begin
                        acc   <= num_q;
                        state <= (len_q == '0) ? S_DONE : S_DBL;
                    end
                end
                S_DBL: begin
                    acc <= dbl;
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    mm_out <= acc;
                    md_end <= 1'b1;
                    md_err <= err;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_to_domain.sv
// Directed and random checks of mont_to_domain: results, error flagging, latency,
// busy/md_end timing, start rejection while busy and reset abort.
module tb_mont_to_domain;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;
    localparam int MAX_WAIT = 400;

    logic             clk;
    logic             rstn;
    logic             md_start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] num_1;
    logic [WIDTH-1:0] modulus;
    logic             md_end;
    logic             md_err;
    logic             busy;
    logic [WIDTH-1:0] mm_out;

    int n_tests = 0;
    int n_fail  = 0;

    mont_to_domain #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .md_start (md_start),
        .len      (len),
        .num_1    (num_1),
        .modulus  (modulus),
        .md_end   (md_end),
        .md_err   (md_err),
        .busy     (busy),
        .mm_out   (mm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a start pulse; returns at #1 after the sampling edge with inputs scrambled.
    task automatic start_op(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m,
                            input logic [LEN_W-1:0] l);
        @(negedge clk);
        md_start = 1'b1;
        num_1    = n;
        modulus  = m;
        len      = l;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        num_1    = $urandom;
        modulus  = $urandom;
        len      = LEN_W'($urandom);
    endtask

    // Waits for md_end counting edges from the start edge; also watches busy and the hold cycle.
    task automatic wait_done(input int lat0, output logic [WIDTH-1:0] out, output logic err,
                             output int lat, output logic busy_ok, output logic post_ok);
        lat     = lat0;
        busy_ok = 1'b1;
        post_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (md_end === 1'b1) break;
            if (lat > MAX_WAIT) break;
        end
        out = mm_out;
        err = md_err;
        if (lat <= MAX_WAIT) begin
            @(posedge clk);
            #1;
            post_ok = (md_end === 1'b0) && (busy === 1'b0) && (mm_out === out);
        end
    endtask

    task automatic run_and_check(input string name, input logic [WIDTH-1:0] n,
                                 input logic [WIDTH-1:0] m, input logic [LEN_W-1:0] l,
                                 input logic [WIDTH-1:0] exp_out, input logic exp_err);
        logic [WIDTH-1:0] out;
        logic             err;
        int               lat;
        logic             busy_ok;
        logic             post_ok;
        int               exp_lat;
        exp_lat = exp_err ? 2 : int'(l) + 2;
        start_op(n, m, l);
        wait_done(0, out, err, lat, busy_ok, post_ok);
        n_tests++;
        if (out !== exp_out) begin
            n_fail++;
            $display("FAIL %s mm_out: got %h expected %h", name, out, exp_out);
        end
        n_tests++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s md_err: got %b expected %b", name, err, exp_err);
        end
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (busy_ok !== 1'b1 || post_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s handshake: busy_ok %b post_ok %b expected 1 1",
                     name, busy_ok, post_ok);
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        md_start = 1'b0;
        len      = '0;
        num_1    = '0;
        modulus  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({md_end, md_err, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset flags: got %b expected 000", {md_end, md_err, busy});
        end
        n_tests++;
        if (mm_out !== '0) begin
            n_fail++;
            $display("FAIL reset mm_out: got %h expected 0", mm_out);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        run_and_check("basic_5_13_4", 32'd5, 32'd13, 8'd4, 32'd2, 1'b0);
        run_and_check("len_zero_7_13", 32'd7, 32'd13, 8'd0, 32'd7, 1'b0);
        run_and_check("small_3_7_5", 32'd3, 32'd7, 8'd5, 32'd5, 1'b0);
    endtask

    task automatic test_carry();
        run_and_check("carry_bit32", 32'hFFFF_FFFA, 32'hFFFF_FFFB, 8'd32, 32'hFFFF_FFF6, 1'b0);
    endtask

    task automatic test_errors();
        run_and_check("err_even_mod", 32'd5, 32'd12, 8'd3, 32'd0, 1'b1);
        run_and_check("err_zero_mod", 32'd0, 32'd0, 8'd3, 32'd0, 1'b1);
        run_and_check("err_num_eq_mod", 32'd13, 32'd13, 8'd3, 32'd0, 1'b1);
    endtask

    task automatic test_max_len();
        // 2^12 = 1 mod 13, so 2^255 = 2^3 = 8 mod 13.
        run_and_check("max_len_255", 32'd1, 32'd13, 8'd255, 32'd8, 1'b0);
    endtask

    task automatic test_repulse();
        logic [WIDTH-1:0] out;
        logic             err;
        int               lat;
        logic             busy_ok;
        logic             post_ok;
        start_op(32'd5, 32'd13, 8'd4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        md_start = 1'b1;
        num_1    = 32'd1;
        modulus  = 32'd11;
        len      = 8'd200;
        @(posedge clk);
        #1;
        md_start = 1'b0;
        wait_done(3, out, err, lat, busy_ok, post_ok);
        n_tests++;
        if (out !== 32'd2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL repulse result: got %h/%b expected 2/0", out, err);
        end
        n_tests++;
        if (lat !== 6 || post_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL repulse timing: got lat %0d post %b expected 6 1", lat, post_ok);
        end
    endtask

    task automatic test_reset_mid();
        int ends;
        start_op(32'd9, 32'd13, 8'd100);
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({md_end, md_err, busy} !== 3'b000 || mm_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %b %h expected 000 0",
                     {md_end, md_err, busy}, mm_out);
        end
        @(negedge clk);
        rstn = 1'b1;
        ends = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (md_end === 1'b1) ends++;
        end
        n_tests++;
        if (ends !== 0) begin
            n_fail++;
            $display("FAIL reset_mid md_end after abort: got %0d expected 0", ends);
        end
        run_and_check("after_reset", 32'd5, 32'd13, 8'd4, 32'd2, 1'b0);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] n;
        logic [LEN_W-1:0] l;
        longint unsigned  r;
        for (int i = 0; i < 1000; i++) begin
            m = $urandom | 32'd1;
            if (i % 4 == 0) m = m >> $urandom_range(0, 28);
            m = m | 32'd1;
            n = $urandom % m;
            l = LEN_W'($urandom_range(0, 40));
            r = longint'(n);
            for (int k = 0; k < int'(l); k++) r = (r << 1) % longint'(m);
            run_and_check($sformatf("random_%0d", i), n, m, l, WIDTH'(r), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_errors();
        test_max_len();
        test_repulse();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
